// File: rtl/instr_seq_unit_if.sv
// rtl/instr_seq_unit_if.sv - load/start/result bundle between the sequencer and its host
interface instr_seq_unit_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [2+2*WIDTH:0]     wr_data;
   logic                   start;
   logic [ADDR_W:0]        prog_len;
   logic                   busy;
   logic                   done;
   logic [2:0]             alu_sel;
   logic                   res_valid;
   logic [ADDR_W-1:0]      res_addr;
   logic [WIDTH-1:0]       res_data;
   logic                   res_carry;
   logic [WIDTH-1:0]       acc_out;

   modport master (
      output wr_en, wr_addr, wr_data, start, prog_len,
      input  busy, done, alu_sel, res_valid, res_addr, res_data, res_carry, acc_out
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, prog_len,
      output busy, done, alu_sel, res_valid, res_addr, res_data, res_carry, acc_out
   );
endinterface

// File: rtl/instr_seq_unit.sv
// rtl/instr_seq_unit.sv - instruction memory plus sequencer driving an internal ALU
// Optional INSTR_SEQ_CHAIN_EN: operand a of every instruction after the first is the previous result.
module instr_seq_unit #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   instr_seq_unit_if.slave    bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int IW    = 3 + 2 * WIDTH;
   localparam int CW    = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DIV, S_EXEC, S_FIN} state_t;
   state_t state, state_nxt;

   logic [IW-1:0]     mem [DEPTH];
   logic [IW-1:0]     fetch_word;
   logic [WIDTH-1:0]  a_eff;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W:0]   len, pc_inc;
   logic [2:0]        op;
   logic [WIDTH-1:0]  a, b;
   logic [WIDTH-1:0]  rem, quo, rem_nxt, quo_nxt;
   logic [WIDTH:0]    shifted, trial;
   logic [CW-1:0]     cnt;
   logic [WIDTH:0]    sum;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]  alu_r;
   logic              alu_c;
   logic              res_valid_q, res_carry_q, done_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic [WIDTH-1:0]  res_data_q, acc_q;

   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.wr_en)
         mem[bus.wr_addr] <= bus.wr_data;
   end

   assign fetch_word = mem[pc];
   assign pc_inc     = {1'b0, pc} + (ADDR_W+1)'(1);

`ifdef INSTR_SEQ_CHAIN_EN
   assign a_eff = (pc != '0) ? acc_q : fetch_word[2*WIDTH-1:WIDTH];
`else
   assign a_eff = fetch_word[2*WIDTH-1:WIDTH];
`endif

   // One restoring-division step per DIV cycle; quotient bits shift in from the right.
   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, b};
   assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

   assign sum  = {1'b0, a} + {1'b0, b};
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      case (op)
         3'b000: begin alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
         3'b001: begin alu_r = a - b; alu_c = (a < b); end
         3'b010: alu_r = a & b;
         3'b011: alu_r = a | b;
         3'b100: alu_r = a ^ b;
         3'b101: begin alu_r = prod[WIDTH-1:0]; alu_c = |prod[2*WIDTH-1:WIDTH]; end
         3'b110: begin
            if (b == '0) begin
               alu_r = '1;
               alu_c = 1'b1;
            end else begin
               alu_r = quo;
            end
         end
         default: alu_r = WIDTH'({(a < b), (a > b), (a == b)});
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = (bus.prog_len == '0) ? S_FIN : S_FETCH;
         S_FETCH: state_nxt = (fetch_word[IW-1:IW-3] == 3'b110) ? S_DIV : S_EXEC;
         S_DIV:   if (cnt == CW'(WIDTH-1)) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = (pc_inc == len) ? S_FIN : S_FETCH;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= '0;
         len         <= '0;
         op          <= '0;
         a           <= '0;
         b           <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         acc_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  pc    <= '0;
                  acc_q <= '0;
                  len   <= (bus.prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.prog_len;
               end
            end
            S_FETCH: begin
               op  <= fetch_word[IW-1:IW-3];
               a   <= a_eff;
               b   <= fetch_word[WIDTH-1:0];
               rem <= '0;
               quo <= a_eff;
               cnt <= '0;
            end
            S_DIV: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt + CW'(1);
            end
            S_EXEC: begin
               res_valid_q <= 1'b1;
               res_addr_q  <= pc;
               res_data_q  <= alu_r;
               res_carry_q <= alu_c;
               acc_q       <= alu_r;
               pc          <= pc + ADDR_W'(1);
            end
            S_FIN:   done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
   assign bus.alu_sel   = op;
   assign bus.res_valid = res_valid_q;
   assign bus.res_addr  = res_addr_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_carry = res_carry_q;
   assign bus.acc_out   = acc_q;
endmodule
